// File: rtl/connect4_pkg.sv
// Shared board geometry, player/winner codes, scan directions and FSM encoding
// for the connect-four win checker.
package connect4_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = 42;

  localparam logic [2:0] ROW_LAST = 3'(ROWS - 1);
  localparam logic [2:0] COL_LAST = 3'(COLS - 1);

  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef enum logic [1:0] {
    DIR_H = 2'd0,  // +col
    DIR_V = 2'd1,  // +row
    DIR_D = 2'd2,  // +row,+col
    DIR_A = 2'd3   // +row,-col
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } state_e;

  function automatic logic anchor_in_bounds(input dir_e d, input logic [2:0] row,
                                            input logic [2:0] col);
    case (d)
      DIR_H:   return (col <= 3'd3);
      DIR_V:   return (row <= 3'd2);
      DIR_D:   return (row <= 3'd2) && (col <= 3'd3);
      default: return (row <= 3'd2) && (col >= 3'd3);
    endcase
  endfunction

  // Index of the k-th cell of a window; cells falling off the board map to 0
  // so the lookup never leaves the vector (such anchors are masked anyway).
  function automatic logic [5:0] cell_index(input dir_e d, input logic [2:0] row,
                                            input logic [2:0] col, input logic [1:0] k);
    int r;
    int c;
    int kk;
    r  = int'(row);
    c  = int'(col);
    kk = int'(k);
    case (d)
      DIR_H:   c = c + kk;
      DIR_V:   r = r + kk;
      DIR_D:   begin r = r + kk; c = c + kk; end
      default: begin r = r + kk; c = c - kk; end
    endcase
    if (r >= ROWS || c < 0 || c >= COLS) return '0;
    return 6'(r * COLS + c);
  endfunction

endpackage

// File: rtl/win_window_eval.sv
// Four-cell window compare: all four occupied and owned by the same player.
module win_window_eval (
  input  logic [3:0] i_occ,
  input  logic [3:0] i_own,
  output logic       o_match,
  output logic       o_owner
);

  assign o_match = (&i_occ) && ((&i_own) || ~(|i_own));
  assign o_owner = i_own[0];

endmodule

// File: rtl/win_checker.sv
// Connect-four win checker: snapshots a board and scans one anchor per cycle
// for a four-in-a-row, reporting winner, winning mask or draw.
//
// state     | meaning
// ST_IDLE   | waiting for start, results held
// ST_SCAN   | evaluating one anchor per cycle (busy)
// ST_REPORT | results valid for one cycle (done)
module win_checker
  import connect4_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CELLS-1:0] gameboard,
  input  logic [CELLS-1:0] players_cells,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic             draw,
  output logic [CELLS-1:0] win_cells
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [1:0]       r_dir;
  logic [2:0]       r_row;
  logic [2:0]       r_col;
  logic [CELLS-1:0] r_board;
  logic [CELLS-1:0] r_owner;
  logic [1:0]       r_winner;
  logic             r_draw;
  logic [CELLS-1:0] r_win_cells;

  logic [3:0]       w_occ;
  logic [3:0]       w_own;
  logic [CELLS-1:0] w_mask;
  logic             w_in_bounds;
  logic             w_eval_match;
  logic             w_eval_owner;
  logic             w_match;
  logic             w_last;
  logic             w_accept;

  always_comb begin
    logic [5:0] w_idx;
    w_occ  = '0;
    w_own  = '0;
    w_mask = '0;
    for (int k = 0; k < 4; k++) begin
      w_idx         = cell_index(dir_e'(r_dir), r_row, r_col, 2'(k));
      w_occ[k]      = r_board[w_idx];
      w_own[k]      = r_owner[w_idx];
      w_mask[w_idx] = 1'b1;
    end
  end

  win_window_eval u_eval (
    .i_occ   (w_occ),
    .i_own   (w_own),
    .o_match (w_eval_match),
    .o_owner (w_eval_owner)
  );

  assign w_in_bounds = anchor_in_bounds(dir_e'(r_dir), r_row, r_col);
  assign w_match     = w_in_bounds && w_eval_match;
  assign w_last      = (r_dir == 2'd3) && (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_accept    = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        busy = 1'b1;
        if (w_match || w_last) w_state_nxt = ST_REPORT;
      end
      ST_REPORT: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dir       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_board     <= '0;
      r_owner     <= '0;
      r_winner    <= WIN_NONE;
      r_draw      <= 1'b0;
      r_win_cells <= '0;
    end else if (w_accept) begin
      r_dir       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_board     <= gameboard;
      r_owner     <= players_cells;
      r_winner    <= WIN_NONE;
      r_draw      <= 1'b0;
      r_win_cells <= '0;
    end else if (r_state == ST_SCAN) begin
      if (w_match) begin
        r_winner    <= (w_eval_owner == PLAYER_P2) ? WIN_P2 : WIN_P1;
        r_win_cells <= w_mask;
      end else if (w_last) begin
        r_draw <= &r_board;
      end else if (r_col == COL_LAST) begin
        r_col <= '0;
        if (r_row == ROW_LAST) begin
          r_row <= '0;
          r_dir <= r_dir + 2'd1;
        end else begin
          r_row <= r_row + 3'd1;
        end
      end else begin
        r_col <= r_col + 3'd1;
      end
    end
  end

  assign winner    = r_winner;
  assign draw      = r_draw;
  assign win_cells = r_win_cells;

endmodule

// File: doc/win_checker.md
WIN_CHECKER -- requirements
Module: win_checker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all flops rising-edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to check the presented board.
REQ-004 SHALL have port gameboard, input, 42 bits: cell occupied=1; index = row*7+col, row 0 = bottom, col 0 = leftmost.
REQ-005 SHALL have port players_cells, input, 42 bits: owner of occupied cell, 0=P1, 1=P2; ignored where gameboard bit=0.
REQ-006 SHALL have port busy, output, 1 bit: scan in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse, results valid.
REQ-008 SHALL have port winner, output, 2 bits: 00 none, 01 P1, 10 P2; 11 never driven.
REQ-009 SHALL have port draw, output, 1 bit: board full and no four-in-a-row.
REQ-010 SHALL have port win_cells, output, 42 bits: mask of the four winning cells, else 0.

Function
REQ-011 SHALL implement FSM IDLE -> SCAN -> REPORT -> IDLE.
REQ-012 SHALL accept start only in IDLE; start in SCAN or REPORT is ignored with no effect.
REQ-013 SHALL, on accepted start, snapshot gameboard and players_cells, clear winner/draw/win_cells, and zero the scan counters dir, row, col.
REQ-014 SHALL evaluate one anchor per SCAN cycle, order n = dir*42 + row*7 + col, col fastest, then row, then dir.
REQ-015 SHALL use directions: dir0 (+col); dir1 (+row); dir2 (+row,+col); dir3 (+row,-col).
REQ-016 SHALL treat an anchor as in-bounds only when: dir0 col<=3; dir1 row<=2; dir2 row<=2 and col<=3; dir3 row<=2 and col>=3; out-of-bounds anchors consume a cycle and never match.
REQ-017 SHALL declare a match when all four cells are occupied and share one owner.
REQ-018 SHALL terminate the scan on the first match, latching winner and win_cells.
REQ-019 SHALL, with start accepted at edge k and the first match at anchor n, pulse done at cycle k+2+n.
REQ-020 SHALL, with no match, finish after anchor 167 with done at k+169, setting draw=1 iff the snapshot gameboard is all ones.
REQ-021 SHALL assert busy exactly in SCAN and done exactly in REPORT.
REQ-022 SHALL hold winner, draw and win_cells stable from done until the next accepted start.
REQ-023 SHALL be insensitive to changes on the board inputs during SCAN.

Reset
REQ-024 SHALL, on reset low, immediately force IDLE with busy, done, draw = 0, winner = 00 and win_cells and snapshots = 0, including mid-scan.
REQ-025 SHALL accept start on the first rising edge after reset deasserts.

Structure
REQ-026 SHALL take ROWS=6, COLS=7, CELLS=42, player codes, the direction encoding and the FSM state encoding from shared package connect4_pkg.
REQ-027 SHALL place the four-cell compare in combinational sub-module win_window_eval, with inputs (four occupied bits, four owner bits) and outputs (match, owner).
REQ-028 SHALL size counters exactly: dir 2 bits, row 3 bits, col 3 bits.

Verification
REQ-029 Empty board, start at k -> busy for 168 cycles, done at k+169, winner=00, draw=0, win_cells=0.
REQ-030 gameboard=0x00F, players_cells=0, start at k -> done at k+2, winner=01, win_cells=0x00F.
REQ-031 Bits 6,13,20,27 occupied by P2, start at k -> n=48, done at k+50, winner=10, win_cells marks those bits.
REQ-032 Full board, P2 iff ((col>>1)+row) odd -> done at k+169, draw=1, winner=00.
REQ-033 Reset low at k+50 during the empty-board scan -> all outputs 0 immediately; a fresh start after release completes normally.
REQ-034 P1 anti-diagonal at cells 6,12,18,24, second start pulsed mid-scan -> second start ignored; n=132, done at k+134, winner=01.
